// File: rtl/score_ssd_driver_pkg.sv
// Shared definitions for the score seven-segment driver: conversion FSM
// encoding, digit-to-cathode table and the double-dabble adjust helper.
package score_ssd_driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } conv_state_e;

    // All segments and the decimal point off (cathodes are active-low).
    localparam logic [7:0] CATH_BLANK = 8'hFF;

    // Cathode patterns {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, index = decimal digit.
    localparam logic [9:0][7:0] SEG_TABLE = {
        8'b00001001,  // 9
        8'b00000001,  // 8
        8'b00011111,  // 7
        8'b01000001,  // 6
        8'b01001001,  // 5
        8'b10011001,  // 4
        8'b00001101,  // 3
        8'b00100101,  // 2
        8'b10011111,  // 1
        8'b00000011   // 0
    };

    // Non-decimal nibbles cannot come out of the converter; show them blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        if (digit > 4'd9) begin
            return CATH_BLANK;
        end
        return SEG_TABLE[digit];
    endfunction

    // One double-dabble correction: every BCD nibble >= 5 gets +3.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] work);
        logic [11:0] res;
        res = work;
        for (int i = 0; i < 3; i++) begin
            if (work[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/score_ssd_driver_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// The displayed digits are only updated in COMMIT, so a half-converted
// value never leaves this block.
module bin2bcd_seq
    import score_ssd_driver_pkg::*;
(
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       start,
    input  logic [7:0] operand,
    output logic       busy,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    conv_state_e state_q, state_d;
    logic [7:0]  opnd_q, opnd_d;
    logic [11:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] digits_q, digits_d;
    logic [11:0] adjusted;

    // State and datapath registers; Reset abandons any conversion in flight.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            opnd_q   <= 8'd0;
            work_q   <= 12'd0;
            cnt_q    <= 4'd0;
            digits_q <= 12'd0;
        end else begin
            state_q  <= state_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
        end
    end

    // Next-state and datapath: LOAD latches, SHIFT runs 8 dabble steps, COMMIT publishes.
    always_comb begin
        state_d  = state_q;
        opnd_d   = opnd_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        adjusted = dabble_adjust(work_q);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                opnd_d  = operand;
                work_d  = 12'd0;
                cnt_d   = 4'd8;
                state_d = SHIFT;
            end
            SHIFT: begin
                work_d = {adjusted[10:0], opnd_q[7]};
                opnd_d = {opnd_q[6:0], 1'b0};
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d = work_q;
                // A start here means a reconversion is queued: skip IDLE.
                state_d  = start ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == COMMIT);
    assign hund  = digits_q[11:8];
    assign tens  = digits_q[7:4];
    assign units = digits_q[3:0];

endmodule

// File: rtl/score_ssd_driver.sv
// Score display driver: detects score changes, converts them to BCD and
// multiplexes three digits onto a common-anode seven-segment display.
module score_ssd_driver
    import score_ssd_driver_pkg::*;
#(
    parameter int unsigned SCAN_BITS     = 18,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic [7:0] score_in,
    input  logic       show,
    output logic       busy,
    output logic [7:0] an,
    output logic [7:0] cathodes
);

    localparam int unsigned SCAN_W = SCAN_BITS + 2;
    localparam logic [SCAN_W-1:0] SCAN_ONE = 1;

    logic [7:0]        last_score_q, last_score_d;
    logic              pending_q, pending_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [7:0]        an_q, an_d;
    logic [7:0]        cath_q, cath_d;

    logic       change;
    logic       start;
    logic       conv_busy;
    logic       conv_done;
    logic [3:0] hund, tens, units;
    logic [1:0] sel;
    logic [3:0] digit;
    logic       blank;
    logic       blank_hund, blank_tens;

    bin2bcd_seq u_conv (
        .board_clk (board_clk),
        .Reset     (Reset),
        .start     (start),
        .operand   (last_score_q),
        .busy      (conv_busy),
        .done      (conv_done),
        .hund      (hund),
        .tens      (tens),
        .units     (units)
    );

    // Control and display registers.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            last_score_q <= 8'd0;
            pending_q    <= 1'b0;
            scan_q       <= '0;
            an_q         <= 8'hFF;
            cath_q       <= CATH_BLANK;
        end else begin
            last_score_q <= last_score_d;
            pending_q    <= pending_d;
            scan_q       <= scan_d;
            an_q         <= an_d;
            cath_q       <= cath_d;
        end
    end

    // Change detection, reconversion queueing and the free-running scan counter.
    always_comb begin
        last_score_d = score_in;
        scan_d       = scan_q + SCAN_ONE;
        pending_d    = pending_q;
        change       = (score_in != last_score_q);
        // From COMMIT the operand is last_score, i.e. the newest sample.
        start        = (!conv_busy && change) || (conv_done && (pending_q || change));
        if (conv_done) begin
            pending_d = 1'b0;
        end else if (conv_busy && change) begin
            pending_d = 1'b1;
        end
    end

    // Digit select, leading-zero blanking and segment encoding.
    always_comb begin
        sel        = scan_q[SCAN_W-1 -: 2];
        blank_hund = (BLANK_LEADING != 0) && (hund == 4'd0);
        blank_tens = (BLANK_LEADING != 0) && (hund == 4'd0) && (tens == 4'd0);
        digit      = 4'd0;
        blank      = 1'b1;
        case (sel)
            2'd0: begin
                digit = units;
                blank = 1'b0;
            end
            2'd1: begin
                digit = tens;
                blank = blank_tens;
            end
            2'd2: begin
                digit = hund;
                blank = blank_hund;
            end
            default: begin
                digit = 4'd0;
                blank = 1'b1;
            end
        endcase
        an_d   = 8'hFF;
        cath_d = CATH_BLANK;
        if (show && !blank) begin
            an_d   = ~(8'h01 << sel);
            cath_d = seg_encode(digit);
        end
    end

    assign busy     = conv_busy;
    assign an       = an_q;
    assign cathodes = cath_q;

endmodule

// File: tb/tb_score_ssd_driver.sv
// Directed bench for score_ssd_driver with a small scan-phase model and a
// queue of expected displayed scores.
module tb_score_ssd_driver;

    logic       board_clk;
    logic       Reset;
    logic [7:0] score_in;
    logic       show;
    logic       busy;
    logic [7:0] an;
    logic [7:0] cathodes;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int exp_q[$];

    score_ssd_driver #(
        .SCAN_BITS     (2),
        .BLANK_LEADING (1)
    ) dut (
        .board_clk (board_clk),
        .Reset     (Reset),
        .score_in  (score_in),
        .show      (show),
        .busy      (busy),
        .an        (an),
        .cathodes  (cathodes)
    );

    initial board_clk = 1'b0;
    always #5 board_clk = ~board_clk;

    // Cycles since reset release: tracks the 16-cycle scan position.
    always @(posedge board_clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [7:0] ref_seg(input int d);
        case (d)
            0: return 8'b00000011;
            1: return 8'b10011111;
            2: return 8'b00100101;
            3: return 8'b00001101;
            4: return 8'b10011001;
            5: return 8'b01001001;
            6: return 8'b01000001;
            7: return 8'b00011111;
            8: return 8'b00000001;
            9: return 8'b00001001;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Walk one full scan period and compare every registered anode/cathode value.
    task automatic check_scan(input int score, input bit shown, input string tag);
        int h, t, u, s, d;
        bit bh, bt, bl;
        logic [7:0] ea, ec;
        h  = score / 100;
        t  = (score / 10) % 10;
        u  = score % 10;
        bh = (h == 0);
        bt = (h == 0) && (t == 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge board_clk);
            s = ((cyc - 1) % 16) / 4;
            case (s)
                0:       begin d = u; bl = 1'b0; end
                1:       begin d = t; bl = bt;   end
                2:       begin d = h; bl = bh;   end
                default: begin d = 0; bl = 1'b1; end
            endcase
            if (!shown || bl) begin
                ea = 8'hFF;
                ec = 8'hFF;
            end else begin
                ea = ~(8'h01 << s);
                ec = ref_seg(d);
            end
            check($sformatf("%s.an.s%0d", tag, s), 32'(an), 32'(ea));
            check($sformatf("%s.cath.s%0d", tag, s), 32'(cathodes), 32'(ec));
        end
    endtask

    // Drive a new score and count busy cycles; optional mid-conversion changes.
    task automatic run_conv(input logic [7:0] v0, input int c1, input logic [7:0] v1,
                            input int c2, input logic [7:0] v2, output int n);
        n = 0;
        score_in = v0;
        for (int k = 0; k < 80; k++) begin
            @(negedge board_clk);
            if (busy) begin
                n++;
                if (n == c1) score_in = v1;
                if (n == c2) score_in = v2;
            end else if (n > 0) begin
                break;
            end
        end
    endtask

    initial begin
        int n;
        int e;
        Reset    = 1'b1;
        score_in = 8'd0;
        show     = 1'b1;
        repeat (3) @(negedge board_clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.an", 32'(an), 32'hFF);
        check("rst.cath", 32'(cathodes), 32'hFF);
        Reset = 1'b0;

        // Score 0 after reset: no conversion, units shows 0, rest blank.
        repeat (4) @(negedge board_clk);
        check("zero.busy", 32'(busy), 32'd0);
        check_scan(0, 1'b1, "zero");

        // 0 -> 255.
        exp_q.push_back(255);
        run_conv(8'd255, 0, 8'd0, 0, 8'd0, n);
        check("c255.busy_cycles", 32'(n), 32'd10);
        e = exp_q.pop_front();
        check_scan(e, 1'b1, "c255");

        // 7, then 42 and 99 during the conversion: one reconversion of 99.
        exp_q.push_back(99);
        run_conv(8'd7, 3, 8'd42, 5, 8'd99, n);
        check("c99.busy_cycles", 32'(n), 32'd20);
        check("c99.busy_after", 32'(busy), 32'd0);
        e = exp_q.pop_front();
        check_scan(e, 1'b1, "c99");

        // 105: zero tens shown because hundreds is nonzero.
        exp_q.push_back(105);
        run_conv(8'd105, 0, 8'd0, 0, 8'd0, n);
        check("c105.busy_cycles", 32'(n), 32'd10);
        e = exp_q.pop_front();
        check_scan(e, 1'b1, "c105");

        // 88 converted while the display is off, then turned back on.
        show = 1'b0;
        exp_q.push_back(88);
        run_conv(8'd88, 0, 8'd0, 0, 8'd0, n);
        check("c88.busy_cycles", 32'(n), 32'd10);
        e = exp_q.pop_front();
        check_scan(e, 1'b0, "c88off");
        show = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge board_clk);
            if (busy) n++;
        end
        check("c88.no_reconv", 32'(n), 32'd0);
        check_scan(e, 1'b1, "c88on");

        // Reset during the 4th SHIFT cycle of a conversion to 200.
        score_in = 8'd200;
        n = 0;
        for (int k = 0; k < 20 && n < 5; k++) begin
            @(negedge board_clk);
            if (busy) n++;
        end
        check("rmid.reached", 32'(n), 32'd5);
        #2 Reset = 1'b1;
        #1;
        check("rmid.busy", 32'(busy), 32'd0);
        check("rmid.an", 32'(an), 32'hFF);
        check("rmid.cath", 32'(cathodes), 32'hFF);
        score_in = 8'd13;
        @(negedge board_clk);
        @(negedge board_clk);
        Reset = 1'b0;
        exp_q.push_back(13);
        @(negedge board_clk);
        check("rmid.start_busy", 32'(busy), 32'd1);
        check("rmid.units0.an", 32'(an), 32'hFE);
        check("rmid.units0.cath", 32'(cathodes), 32'h03);
        n = busy ? 1 : 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge board_clk);
            if (busy) n++;
            else break;
        end
        check("c13.busy_cycles", 32'(n), 32'd10);
        e = exp_q.pop_front();
        check_scan(e, 1'b1, "c13");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
